unified_mem_arbiter: RTL and testbench

//   Shares one single-port memory between the core's instruction-fetch port and its load/store port.

---
 rtl/unified_mem_arbiter_if.sv | 31 +++
 rtl/unified_mem_arbiter.sv | 64 ++++++
 tb/tb_unified_mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch port, load/store port and memory macro port of the arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_ctrl;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_ctrl, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_ctrl, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and load/store ports; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  gnt_d
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       we_q;
  logic       last_cyc;
  logic       pick_d;
  logic       start;
  // next state, grant decision and strobes derived from the current state
  always_comb begin
    last_cyc = state == ACCESS && cnt == 4'd1;
    start    = state == IDLE && (bus.if_req || bus.d_req);
`ifdef ARB_ROUND_ROBIN_EN
    pick_d   = bus.d_req && (!bus.if_req || !gnt_d);
`else
    pick_d   = bus.d_req;
`endif
    state_nx = state == IDLE ? (start ? ACCESS : IDLE) :
               state == ACCESS ? (last_cyc ? DONE : ACCESS) : IDLE;
    busy         = state != IDLE;
    bus.mem_en   = state == ACCESS;
    bus.mem_we   = last_cyc && we_q;
    bus.if_ready = state == DONE && !gnt_d;
    bus.d_ready  = state == DONE && gnt_d;
  end
  // state register, grant latch, access counter and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      gnt_d         <= 1'b0;
      we_q          <= 1'b0;
      bus.mem_ctrl  <= 3'b000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        gnt_d         <= pick_d;
        cnt           <= 4'(MEM_LATENCY);
        we_q          <= pick_d && bus.d_we;
        bus.mem_ctrl  <= pick_d ? bus.d_ctrl : 3'b010;
        bus.mem_addr  <= ADDR_W'(pick_d ? bus.d_addr : bus.if_addr);
        bus.mem_wdata <= pick_d ? bus.d_wdata : DATA_W'(0);
      end
      if (state == ACCESS) cnt <= cnt - 4'd1;
      if (last_cyc && !gnt_d) bus.if_rdata <= bus.mem_rdata;
      if (last_cyc && gnt_d && !we_q) bus.d_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed table and sequence checks for unified_mem_arbiter at latency 1 and 3
module tb_unified_mem_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic busy_a, gnt_a, busy_b, gnt_b;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .busy(busy_a), .gnt_d(gnt_a));
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .busy(busy_b), .gnt_d(gnt_b));
  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_ctrl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] mem_rdata;
    logic        exp_gnt;
    logic [31:0] exp_addr;
    logic [2:0]  exp_ctrl;
    logic        exp_we;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_b(input int n, output int en_n, output int we_n, output int we_at,
                       output int ir_n, output int ir_at, output int dr_n, output int dr_at,
                       output logic g_first);
    en_n = 0; we_n = 0; we_at = 0; ir_n = 0; ir_at = 0; dr_n = 0; dr_at = 0; g_first = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (ifb.mem_en) begin
        if (en_n == 0) g_first = gnt_b;
        en_n++;
      end
      if (ifb.mem_we) begin we_n++; we_at = k; end
      if (ifb.if_ready) begin ir_n++; ir_at = k; ifb.if_req = 0; end
      if (ifb.d_ready) begin dr_n++; dr_at = k; ifb.d_req = 0; end
    end
  endtask
  initial begin
    vec_t        vt[6];
    logic [31:0] m_if, m_d;
    logic        last_g, g, gf;
    logic [31:0] ea;
    logic [2:0]  ec;
    logic        ew;
    int          en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at;
    logic        seq[4];
    int          n_srv;
    vt[0] = '{1'b0, 1'b0, 3'b000, 32'h0,  32'h0,        1'b1, 32'h10, 32'h00500093, 1'b0, 32'h10, 3'b010, 1'b0};
    vt[1] = '{1'b1, 1'b0, 3'b100, 32'h20, 32'h0,        1'b0, 32'h0,  32'h11223344, 1'b1, 32'h20, 3'b100, 1'b0};
    vt[2] = '{1'b1, 1'b1, 3'b001, 32'h44, 32'hCAFEF00D, 1'b0, 32'h0,  32'h00000055, 1'b1, 32'h44, 3'b001, 1'b1};
    vt[3] = '{1'b1, 1'b0, 3'b000, 32'h80, 32'h0,        1'b1, 32'h14, 32'h00000077, 1'b1, 32'h80, 3'b000, 1'b0};
    vt[4] = '{1'b0, 1'b1, 3'b100, 32'h90, 32'h1234,     1'b1, 32'h18, 32'h00000088, 1'b0, 32'h18, 3'b010, 1'b0};
    vt[5] = '{1'b1, 1'b1, 3'b010, 32'hA0, 32'hBEEF,     1'b1, 32'h1C, 32'h00000099, 1'b1, 32'hA0, 3'b010, 1'b1};
    {ifa.if_req, ifa.d_req, ifa.d_we, ifb.if_req, ifb.d_req, ifb.d_we} = '0;
    {ifa.if_addr, ifa.d_addr, ifa.d_wdata, ifa.mem_rdata} = '0;
    {ifb.if_addr, ifb.d_addr, ifb.d_wdata, ifb.mem_rdata} = '0;
    ifa.d_ctrl = 0; ifb.d_ctrl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    chk("rst_en_we", {ifa.mem_en, ifa.mem_we, ifb.mem_en, ifb.mem_we}, 0);
    chk("rst_ready", {ifa.if_ready, ifa.d_ready, ifb.if_ready, ifb.d_ready}, 0);
    chk("rst_rdata", ifa.if_rdata | ifa.d_rdata | ifb.if_rdata | ifb.d_rdata, 0);
    chk("rst_mem_addr", ifa.mem_addr | ifb.mem_addr, 0);
    reset = 0;
    m_if = 0; m_d = 0; last_g = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifa.d_req = vt[i].d_req; ifa.d_we = vt[i].d_we; ifa.d_ctrl = vt[i].d_ctrl;
      ifa.d_addr = vt[i].d_addr; ifa.d_wdata = vt[i].d_wdata;
      ifa.if_req = vt[i].if_req; ifa.if_addr = vt[i].if_addr; ifa.mem_rdata = vt[i].mem_rdata;
      g = vt[i].exp_gnt; ea = vt[i].exp_addr; ec = vt[i].exp_ctrl; ew = vt[i].exp_we;
`ifdef ARB_ROUND_ROBIN_EN
      if (vt[i].d_req && vt[i].if_req) g = !last_g;
      if (g != vt[i].exp_gnt) begin
        ea = g ? vt[i].d_addr : vt[i].if_addr;
        ec = g ? vt[i].d_ctrl : 3'b010;
        ew = g && vt[i].d_we;
      end
`endif
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy_a, 1);
      chk($sformatf("v%0d_en", i), ifa.mem_en, 1);
      chk($sformatf("v%0d_we", i), ifa.mem_we, ew);
      chk($sformatf("v%0d_addr", i), ifa.mem_addr, ea);
      chk($sformatf("v%0d_ctrl", i), ifa.mem_ctrl, ec);
      chk($sformatf("v%0d_gnt", i), gnt_a, g);
      if (ew) chk($sformatf("v%0d_wdata", i), ifa.mem_wdata, vt[i].d_wdata);
      ifa.d_req = 0; ifa.if_req = 0;
      @(negedge clk);
      if (!g) m_if = vt[i].mem_rdata;
      else if (!vt[i].d_we) m_d = vt[i].mem_rdata;
      chk($sformatf("v%0d_rdy", i), {ifa.if_ready, ifa.d_ready}, {!g, g});
      chk($sformatf("v%0d_done_en", i), {ifa.mem_en, ifa.mem_we}, 0);
      chk($sformatf("v%0d_if_rdata", i), ifa.if_rdata, m_if);
      chk($sformatf("v%0d_d_rdata", i), ifa.d_rdata, m_d);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {busy_a, ifa.if_ready, ifa.d_ready}, 0);
      last_g = g;
    end
    ifb.d_req = 1; ifb.d_we = 0; ifb.d_addr = 32'h30; ifb.mem_rdata = 32'hA5A5A5A5;
    run_b(6, en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at, gf);
    chk("load_dr_at", dr_at, 4);
    chk("load_d_rdata", ifb.d_rdata, 32'hA5A5A5A5);
    ifb.d_req = 1; ifb.d_we = 1; ifb.d_addr = 32'h40; ifb.d_wdata = 32'hDEADBEEF;
    ifb.d_ctrl = 3'b010; ifb.mem_rdata = 32'h13579BDF;
    run_b(6, en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at, gf);
    chk("st_en_cycles", en_n, 3);
    chk("st_we_count", we_n, 1);
    chk("st_we_at", we_at, 3);
    chk("st_dr_at", dr_at, 4);
    chk("st_dr_count", dr_n, 1);
    chk("st_ir_count", ir_n, 0);
    chk("st_d_rdata_kept", ifb.d_rdata, 32'hA5A5A5A5);
    chk("st_hold_addr", ifb.mem_addr, 32'h40);
    chk("st_hold_wdata", ifb.mem_wdata, 32'hDEADBEEF);
    chk("st_hold_ctrl", ifb.mem_ctrl, 3'b010);
    ifb.d_we = 0;
    ifb.if_req = 1; ifb.if_addr = 32'h100; ifb.mem_rdata = 32'h0BADF00D;
    run_b(6, en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at, gf);
    chk("f_ir_at", ir_at, 4);
    chk("f_if_rdata", ifb.if_rdata, 32'h0BADF00D);
    ifb.if_req = 1; ifb.if_addr = 32'h104; ifb.d_req = 1; ifb.d_addr = 32'h50;
    ifb.d_ctrl = 3'b000; ifb.mem_rdata = 32'h2468ACE0;
    run_b(12, en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at, gf);
    chk("both_first_gnt", gf, 1);
    chk("both_dr_at", dr_at, 4);
    chk("both_ir_at", ir_at, 9);
    chk("both_counts", {ir_n[3:0], dr_n[3:0]}, 8'h11);
    chk("both_if_rdata", ifb.if_rdata, 32'h2468ACE0);
    ifb.if_req = 1; ifb.if_addr = 32'h200; ifb.mem_rdata = 32'h00500093;
    @(negedge clk);
    ifb.if_req = 0;
    run_b(5, en_n, we_n, we_at, ir_n, ir_at, dr_n, dr_at, gf);
    chk("drop_ir_count", ir_n, 1);
    chk("drop_ir_at", ir_at, 3);
    chk("drop_if_rdata", ifb.if_rdata, 32'h00500093);
    ifb.if_req = 1; ifb.d_req = 1; ifb.mem_rdata = 32'h0F0F0F0F;
    n_srv = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if ((ifb.if_ready || ifb.d_ready) && n_srv < 4) begin
        seq[n_srv] = ifb.d_ready;
        n_srv++;
      end
    end
    ifb.if_req = 0; ifb.d_req = 0;
    chk("cont_serviced", n_srv, 4);
    for (int j = 0; j < 4; j++)
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("cont_grant%0d", j), seq[j], (j % 2) == 0);
`else
      chk($sformatf("cont_grant%0d", j), seq[j], 1);
`endif
    repeat (3) @(negedge clk);
    ifb.d_req = 1; ifb.d_we = 1; ifb.d_addr = 32'h60; ifb.d_wdata = 32'hFFFFFFFF; ifb.mem_rdata = 32'h11;
    @(negedge clk);
    chk("rs_c1_we", {ifb.mem_en, ifb.mem_we}, 2'b10);
    @(negedge clk);
    chk("rs_c2_we", {ifb.mem_en, ifb.mem_we}, 2'b10);
    reset = 1; ifb.d_req = 0;
    @(negedge clk);
    chk("rs_busy", busy_b, 0);
    chk("rs_en_we", {ifb.mem_en, ifb.mem_we}, 0);
    chk("rs_ready", {ifb.if_ready, ifb.d_ready}, 0);
    chk("rs_rdata", ifb.if_rdata | ifb.d_rdata, 0);
    chk("rs_mem_addr", ifb.mem_addr, 0);
    reset = 0;
    @(negedge clk);
    chk("rs_after", {busy_b, ifb.mem_we, ifb.d_ready}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
